// File: rtl/hazard_stall_ctrl_if.sv
// Handshake bundle between the ID-stage hazard unit and the pipeline.
// master = pipeline side driving hazard inputs, slave = hazard unit.
interface hazard_stall_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic                  Branch;
    logic                  Comparator_result;
    logic                  ID_EX_MemRead;
    logic                  ID_EX_RegWrite;
    logic [REG_ADDR_W-1:0] ID_EX_Write_Reg;
    logic                  EX_MEM_MemRead;
    logic                  EX_MEM_MemWrite;
    logic [REG_ADDR_W-1:0] EX_MEM_RegisterRt;
    logic [REG_ADDR_W-1:0] IF_ID_RegisterRs;
    logic [REG_ADDR_W-1:0] IF_ID_RegisterRt;
    logic                  IF_ID_UsesRt;

    logic                  pc_freeze;
    logic                  IF_ID_freeze;
    logic                  control_flush;
    logic                  ID_EX_freeze;
    logic                  EX_MEM_freeze;
    logic                  MEM_WB_bubble;
    logic                  take_branch;
    logic                  IF_ID_flush;
    logic                  mem_busy;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output Branch, Comparator_result,
        output ID_EX_MemRead, ID_EX_RegWrite, ID_EX_Write_Reg,
        output EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_RegisterRt,
        output IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_UsesRt,
        input  pc_freeze, IF_ID_freeze, control_flush,
        input  ID_EX_freeze, EX_MEM_freeze, MEM_WB_bubble,
        input  take_branch, IF_ID_flush, mem_busy,
        input  stall_cycles, flush_count
    );

    modport slave (
        input  Branch, Comparator_result,
        input  ID_EX_MemRead, ID_EX_RegWrite, ID_EX_Write_Reg,
        input  EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_RegisterRt,
        input  IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_UsesRt,
        output pc_freeze, IF_ID_freeze, control_flush,
        output ID_EX_freeze, EX_MEM_freeze, MEM_WB_bubble,
        output take_branch, IF_ID_flush, mem_busy,
        output stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard/stall controller: data hazards plus memory-latency freeze.
// Optional performance counters enabled by defining HAZ_PERF_CNT_EN.
module hazard_stall_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MEM_LAT    = 1,
    parameter int CNT_W      = 32
) (
    input logic               clk,
    input logic               rst_n,
    hazard_stall_ctrl_if.slave hz
);
    localparam int CW = $clog2(MEM_LAT) + 1;
    localparam logic [CW-1:0] RELOAD = CW'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
    localparam logic LAT_GT1 = (MEM_LAT > 1);

    typedef enum logic {IDLE, WAIT} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic mem_stall;
    logic data_stall;
    logic acc;
    logic lu, br_alu, br_ld;
    logic m_idex, m_exmem;

    logic pc_freeze, if_id_freeze, control_flush;
    logic id_ex_freeze, ex_mem_freeze, mem_wb_bubble;
    logic take_branch, mem_busy;

    function automatic logic match(
        input logic [REG_ADDR_W-1:0] x,
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rt,
        input logic                  uses_rt
    );
        return (x != '0) && ((x == rs) || (uses_rt && (x == rt)));
    endfunction

    always_comb begin
        m_idex  = match(hz.ID_EX_Write_Reg, hz.IF_ID_RegisterRs,
                        hz.IF_ID_RegisterRt, hz.IF_ID_UsesRt);
        m_exmem = match(hz.EX_MEM_RegisterRt, hz.IF_ID_RegisterRs,
                        hz.IF_ID_RegisterRt, hz.IF_ID_UsesRt);
        lu      = hz.ID_EX_MemRead && m_idex;
        br_alu  = hz.Branch && hz.ID_EX_RegWrite
                  && !hz.ID_EX_MemRead && m_idex;
        br_ld   = hz.Branch && hz.EX_MEM_MemRead && m_exmem;
        data_stall = lu || br_alu || br_ld;
        acc     = hz.EX_MEM_MemRead || hz.EX_MEM_MemWrite;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The access cycle itself stalls from IDLE; WAIT covers the remainder.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_stall = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (acc && LAT_GT1) begin
                    mem_stall = 1'b1;
                    state_d   = WAIT;
                    cnt_d     = RELOAD;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q - CW'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        pc_freeze     = 1'b0;
        if_id_freeze  = 1'b0;
        control_flush = 1'b0;
        id_ex_freeze  = 1'b0;
        ex_mem_freeze = 1'b0;
        mem_wb_bubble = 1'b0;
        take_branch   = 1'b0;
        mem_busy      = 1'b0;
        if (rst_n) begin
            mem_busy = (state_q == WAIT);
            if (mem_stall) begin
                pc_freeze     = 1'b1;
                if_id_freeze  = 1'b1;
                id_ex_freeze  = 1'b1;
                ex_mem_freeze = 1'b1;
                mem_wb_bubble = 1'b1;
            end else if (data_stall) begin
                pc_freeze     = 1'b1;
                if_id_freeze  = 1'b1;
                control_flush = 1'b1;
            end else begin
                take_branch = hz.Branch && hz.Comparator_result;
            end
        end
    end

    assign hz.pc_freeze     = pc_freeze;
    assign hz.IF_ID_freeze  = if_id_freeze;
    assign hz.control_flush = control_flush;
    assign hz.ID_EX_freeze  = id_ex_freeze;
    assign hz.EX_MEM_freeze = ex_mem_freeze;
    assign hz.MEM_WB_bubble = mem_wb_bubble;
    assign hz.take_branch   = take_branch;
    assign hz.IF_ID_flush   = take_branch;
    assign hz.mem_busy      = mem_busy;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q + CNT_W'(pc_freeze);
        flush_d = flush_q + CNT_W'(take_branch);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign hz.stall_cycles = stall_q;
    assign hz.flush_count  = flush_q;
`else
    assign hz.stall_cycles = {CNT_W{1'b0}};
    assign hz.flush_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl (MEM_LAT=4, 8-bit counters).
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_hazard_stall_ctrl;
    localparam int LAT = 4;
    localparam int CW  = 8;

    logic clk;
    logic rst_n;

    hazard_stall_ctrl_if #(.REG_ADDR_W(5), .CNT_W(CW)) hz ();

    hazard_stall_ctrl #(
        .REG_ADDR_W(5),
        .MEM_LAT(LAT),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .hz(hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       br;
        logic       cmp;
        logic       idmr;
        logic       idrw;
        logic [4:0] idwr;
        logic       exmr;
        logic       exmw;
        logic [4:0] exrt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesrt;
    } stim_t;

    // flags: pc,ifid,cflush,idex,exmem,wb,take,flush,busy
    typedef struct packed {
        logic [8:0]    flags;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
        int            tag;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    int            rem = 0;
    logic [CW-1:0] sc_m = '0;
    logic [CW-1:0] fc_m = '0;
    logic          prev_run = 1'b0;
    logic          prev_pf = 1'b0;
    logic          prev_fl = 1'b0;
    int            tagn = 0;

    function automatic logic hit(input logic [4:0] x, input stim_t s);
        return (x != 0) && (x == s.rs || (s.usesrt && x == s.rt));
    endfunction

    task automatic step(input stim_t s, input logic rstv);
        exp_t e;
        logic ds, ms, busy, tk;
        @(posedge clk);
        #1;
        if (prev_run) begin
            if (rem > 0) rem--;
            sc_m = sc_m + CW'(prev_pf);
            fc_m = fc_m + CW'(prev_fl);
        end
        rst_n                = rstv;
        hz.Branch            = s.br;
        hz.Comparator_result = s.cmp;
        hz.ID_EX_MemRead     = s.idmr;
        hz.ID_EX_RegWrite    = s.idrw;
        hz.ID_EX_Write_Reg   = s.idwr;
        hz.EX_MEM_MemRead    = s.exmr;
        hz.EX_MEM_MemWrite   = s.exmw;
        hz.EX_MEM_RegisterRt = s.exrt;
        hz.IF_ID_RegisterRs  = s.rs;
        hz.IF_ID_RegisterRt  = s.rt;
        hz.IF_ID_UsesRt      = s.usesrt;
        e = '0;
        tagn++;
        e.tag = tagn;
        if (!rstv) begin
            rem  = 0;
            sc_m = '0;
            fc_m = '0;
            prev_pf = 1'b0;
            prev_fl = 1'b0;
        end else begin
            ds = (s.idmr && hit(s.idwr, s))
                 || (s.br && s.idrw && !s.idmr && hit(s.idwr, s))
                 || (s.br && s.exmr && hit(s.exrt, s));
            if (rem == 0 && (s.exmr || s.exmw) && LAT > 1) rem = LAT;
            ms   = (rem > 1);
            busy = (rem > 0) && (rem < LAT);
            tk   = s.br && s.cmp && !ds && !ms;
            if (ms)      e.flags = 9'b110111000;
            else if (ds) e.flags = 9'b111000000;
            else         e.flags = 9'b000000000;
            e.flags[2] = tk;
            e.flags[1] = tk;
            e.flags[0] = busy;
`ifdef HAZ_PERF_CNT_EN
            e.sc = sc_m;
            e.fc = fc_m;
`endif
            prev_pf = e.flags[8];
            prev_fl = tk;
        end
        prev_run = rstv;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [8:0] act;
        if (q.size() > 0) begin
            e = q.pop_front();
            act = {hz.pc_freeze, hz.IF_ID_freeze, hz.control_flush,
                   hz.ID_EX_freeze, hz.EX_MEM_freeze, hz.MEM_WB_bubble,
                   hz.take_branch, hz.IF_ID_flush, hz.mem_busy};
            checks++;
            if (act !== e.flags) begin
                errors++;
                $display("FAIL flags step %0d: got %b expected %b",
                         e.tag, act, e.flags);
            end
            checks++;
            if (hz.stall_cycles !== e.sc) begin
                errors++;
                $display("FAIL stall_cycles step %0d: got %0d expected %0d",
                         e.tag, hz.stall_cycles, e.sc);
            end
            checks++;
            if (hz.flush_count !== e.fc) begin
                errors++;
                $display("FAIL flush_count step %0d: got %0d expected %0d",
                         e.tag, hz.flush_count, e.fc);
            end
        end
    end

    function automatic stim_t rnd();
        stim_t s;
        s.br     = 1'($urandom_range(0, 1));
        s.cmp    = 1'($urandom_range(0, 1));
        s.idmr   = ($urandom_range(0, 3) == 0);
        s.idrw   = 1'($urandom_range(0, 1));
        s.idwr   = 5'($urandom_range(0, 3));
        s.exmr   = ($urandom_range(0, 9) == 0);
        s.exmw   = ($urandom_range(0, 11) == 0);
        s.exrt   = 5'($urandom_range(0, 3));
        s.rs     = 5'($urandom_range(0, 3));
        s.rt     = 5'($urandom_range(0, 3));
        s.usesrt = 1'($urandom_range(0, 1));
        return s;
    endfunction

    initial begin
        stim_t s;
        rst_n = 1'b0;
        s = '0;
        step(s, 1'b0);
        step(s, 1'b0);
        step(s, 1'b1);
        // load-use, then register 0
        s = '0; s.idmr = 1; s.idwr = 8; s.rs = 8;
        step(s, 1'b1);
        s.idwr = 0; s.rs = 0;
        step(s, 1'b1);
        // Rt only counts when read
        s = '0; s.idmr = 1; s.idwr = 9; s.rt = 9; s.rs = 1;
        step(s, 1'b1);
        s.usesrt = 1;
        step(s, 1'b1);
        // branch on ALU result, then clear
        s = '0; s.br = 1; s.cmp = 1; s.idrw = 1; s.idwr = 4; s.rs = 4;
        step(s, 1'b1);
        s.idwr = 5;
        step(s, 1'b1);
        // held load: two back-to-back accesses
        s = '0; s.exmr = 1;
        for (int i = 0; i < 8; i++) step(s, 1'b1);
        s = '0;
        step(s, 1'b1);
        // reset in the middle of WAIT
        s.exmr = 1;
        step(s, 1'b1);
        step(s, 1'b1);
        step(s, 1'b0);
        step(s, 1'b0);
        for (int i = 0; i < 5; i++) step(s, 1'b1);
        s = '0;
        step(s, 1'b1);
        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            s = rnd();
            step(s, ($urandom_range(0, 199) != 0));
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
